// File: rtl/seg7_frame_decoder.sv
// Seven-segment scan decoder: debounces each digit strobe, decodes it and assembles 4-digit frames.
// Optional error counter enabled by defining SEG7_FRAME_DECODER_ERRCNT_EN.
//
// state       | meaning
// WAIT_STABLE | counting stable cycles of registered seg_in/dig_sel
// CAPTURED    | current strobe already written to its slot; waiting for inputs to change
module seg7_frame_decoder #(
   parameter int unsigned STABLE_CYC = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  dig_sel,
   input  logic        frame_ready,
   output logic        frame_valid,
   output logic [15:0] frame_data,
   output logic [3:0]  frame_err,
   output logic [3:0]  frame_blank,
   output logic [7:0]  err_count
);

   typedef enum logic {
      WAIT_STABLE = 1'b0,
      CAPTURED    = 1'b1
   } state_t;

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);
   localparam logic [7:0] CNT_CAP = 8'(STABLE_CYC - 2);

   state_t      state_q, state_d;
   logic [6:0]  seg_r_q, seg_p_q;
   logic [3:0]  dig_r_q, dig_p_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  captured_q, captured_d;
   logic [15:0] slot_nib_q, slot_nib_d;
   logic [3:0]  slot_err_q, slot_err_d;
   logic [3:0]  slot_blank_q, slot_blank_d;
   logic        frame_valid_q, frame_valid_d;
   logic [15:0] frame_data_q, frame_data_d;
   logic [3:0]  frame_err_q, frame_err_d;
   logic [3:0]  frame_blank_q, frame_blank_d;

   logic [3:0]  dec_nib;
   logic        dec_err;
   logic        dec_blank;
   logic        dig_valid;
   logic [1:0]  dig_idx;
   logic        changed;
   logic        capture;
   logic        load;

   always_comb begin
      dec_nib   = 4'h0;
      dec_err   = 1'b0;
      dec_blank = 1'b0;
      case (seg_r_q)
         7'b1000000: dec_nib = 4'h0;
         7'b1111001: dec_nib = 4'h1;
         7'b0100100: dec_nib = 4'h2;
         7'b0110000: dec_nib = 4'h3;
         7'b0011001: dec_nib = 4'h4;
         7'b0010010: dec_nib = 4'h5;
         7'b0000010: dec_nib = 4'h6;
         7'b1111000: dec_nib = 4'h7;
         7'b0000000: dec_nib = 4'h8;
         7'b0010000: dec_nib = 4'h9;
         7'b0001000: dec_nib = 4'hA;
         7'b0000011: dec_nib = 4'hB;
         7'b1000110: dec_nib = 4'hC;
         7'b0100001: dec_nib = 4'hD;
         7'b0000110: dec_nib = 4'hE;
         7'b0001110: dec_nib = 4'hF;
         7'b1111111: dec_blank = 1'b1;
         default:    dec_err = 1'b1;
      endcase
   end

   always_comb begin
      dig_valid = 1'b1;
      dig_idx   = 2'd0;
      case (dig_r_q)
         4'b1110: dig_idx = 2'd0;
         4'b1101: dig_idx = 2'd1;
         4'b1011: dig_idx = 2'd2;
         4'b0111: dig_idx = 2'd3;
         default: dig_valid = 1'b0;
      endcase
   end

   assign changed = (seg_r_q != seg_p_q) || (dig_r_q != dig_p_q);

   // Capture fires on the edge where the counter would reach STABLE_CYC-1,
   // i.e. after STABLE_CYC consecutive identical registered samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         WAIT_STABLE: begin
            if (changed) begin
               cnt_d = 8'd0;
            end else begin
               if (cnt_q < CNT_MAX) cnt_d = cnt_q + 8'd1;
               if (dig_valid && (cnt_q == CNT_CAP)) begin
                  capture = 1'b1;
                  state_d = CAPTURED;
               end
            end
         end
         CAPTURED: begin
            if (changed) begin
               state_d = WAIT_STABLE;
               cnt_d   = 8'd0;
            end
         end
         default: begin
            state_d = WAIT_STABLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign load = (captured_q == 4'hF) && (!frame_valid_q || frame_ready);

   always_comb begin
      captured_d    = load ? 4'h0 : captured_q;
      slot_nib_d    = slot_nib_q;
      slot_err_d    = slot_err_q;
      slot_blank_d  = slot_blank_q;
      frame_valid_d = frame_valid_q;
      frame_data_d  = frame_data_q;
      frame_err_d   = frame_err_q;
      frame_blank_d = frame_blank_q;
      if (capture) begin
         captured_d[dig_idx]          = 1'b1;
         slot_nib_d[{dig_idx, 2'b00} +: 4] = dec_nib;
         slot_err_d[dig_idx]          = dec_err;
         slot_blank_d[dig_idx]        = dec_blank;
      end
      if (load) begin
         frame_valid_d = 1'b1;
         frame_data_d  = slot_nib_q;
         frame_err_d   = slot_err_q;
         frame_blank_d = slot_blank_q;
      end else if (frame_valid_q && frame_ready) begin
         frame_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT_STABLE;
         seg_r_q       <= 7'h7F;
         dig_r_q       <= 4'hF;
         seg_p_q       <= 7'h7F;
         dig_p_q       <= 4'hF;
         cnt_q         <= 8'd0;
         captured_q    <= 4'h0;
         slot_nib_q    <= 16'h0000;
         slot_err_q    <= 4'h0;
         slot_blank_q  <= 4'h0;
         frame_valid_q <= 1'b0;
         frame_data_q  <= 16'h0000;
         frame_err_q   <= 4'h0;
         frame_blank_q <= 4'h0;
      end else begin
         state_q       <= state_d;
         seg_r_q       <= seg_in;
         dig_r_q       <= dig_sel;
         seg_p_q       <= seg_r_q;
         dig_p_q       <= dig_r_q;
         cnt_q         <= cnt_d;
         captured_q    <= captured_d;
         slot_nib_q    <= slot_nib_d;
         slot_err_q    <= slot_err_d;
         slot_blank_q  <= slot_blank_d;
         frame_valid_q <= frame_valid_d;
         frame_data_q  <= frame_data_d;
         frame_err_q   <= frame_err_d;
         frame_blank_q <= frame_blank_d;
      end
   end

`ifdef SEG7_FRAME_DECODER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (capture && dec_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= 8'd0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 8'h00;
`endif

   assign frame_valid = frame_valid_q;
   assign frame_data  = frame_data_q;
   assign frame_err   = frame_err_q;
   assign frame_blank = frame_blank_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder; frames expected are queued and checked on handshake.
module tb_seg7_frame_decoder;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  e;
      logic [3:0]  b;
   } frm_t;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg_in;
   logic [3:0]  dig_sel;
   logic        frame_ready;
   logic        frame_valid;
   logic [15:0] frame_data;
   logic [3:0]  frame_err;
   logic [3:0]  frame_blank;
   logic [7:0]  err_count;

   int   total = 0;
   int   bad   = 0;
   int   n_hs  = 0;
   int   base;
   frm_t sb[$];

   seg7_frame_decoder #(.STABLE_CYC(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .dig_sel     (dig_sel),
      .frame_ready (frame_ready),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_err   (frame_err),
      .frame_blank (frame_blank),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] pat(input int v);
      case (v)
         0:  pat = 7'b1000000;
         1:  pat = 7'b1111001;
         2:  pat = 7'b0100100;
         3:  pat = 7'b0110000;
         4:  pat = 7'b0011001;
         5:  pat = 7'b0010010;
         6:  pat = 7'b0000010;
         7:  pat = 7'b1111000;
         8:  pat = 7'b0000000;
         9:  pat = 7'b0010000;
         10: pat = 7'b0001000;
         11: pat = 7'b0000011;
         12: pat = 7'b1000110;
         13: pat = 7'b0100001;
         14: pat = 7'b0000110;
         15: pat = 7'b0001110;
         default: pat = 7'b1111111;
      endcase
   endfunction

   task automatic push(input logic [15:0] d, input logic [3:0] e, input logic [3:0] b);
      frm_t f;
      f.d = d;
      f.e = e;
      f.b = b;
      sb.push_back(f);
   endtask

   task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
      dig_sel = sel;
      seg_in  = seg;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic digit(input int k, input logic [6:0] seg, input int cycles);
      logic [3:0] sel;
      sel = 4'hF;
      sel[k] = 1'b0;
      drive(sel, seg, cycles);
   endtask

   task automatic idle(input int cycles);
      drive(4'hF, 7'h7F, cycles);
   endtask

   always @(negedge clk) begin
      if (rst_n && frame_valid && frame_ready) begin
         frm_t f;
         n_hs++;
         if (sb.size() == 0) begin
            chk("unexpected_frame", 32'(frame_data), 32'hFFFF_FFFF);
         end else begin
            f = sb.pop_front();
            chk("frame_data", 32'(frame_data), 32'(f.d));
            chk("frame_err", 32'(frame_err), 32'(f.e));
            chk("frame_blank", 32'(frame_blank), 32'(f.b));
         end
      end
   end

   initial begin
      logic [7:0] exp_errcnt;
      rst_n       = 1'b0;
      seg_in      = 7'h7F;
      dig_sel     = 4'hF;
      frame_ready = 1'b1;
      #1;
      chk("rst_valid", 32'(frame_valid), 32'd0);
      chk("rst_data", 32'(frame_data), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      chk("rst_blank", 32'(frame_blank), 32'd0);
      chk("rst_errcnt", 32'(err_count), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);

      // basic frame 4321
      base = n_hs;
      push(16'h4321, 4'h0, 4'h0);
      digit(0, pat(1), 6);
      digit(1, pat(2), 6);
      digit(2, pat(3), 6);
      digit(3, pat(4), 6);
      idle(6);
      chk("t1_single_frame", 32'(n_hs - base), 32'd1);
      chk("t1_valid_dropped", 32'(frame_valid), 32'd0);

      // undecodable pattern on digit 2
      push(16'h0000, 4'b0100, 4'h0);
      digit(0, pat(0), 6);
      digit(1, pat(0), 6);
      digit(2, 7'b1010101, 6);
      digit(3, pat(0), 6);
      idle(6);
`ifdef SEG7_FRAME_DECODER_ERRCNT_EN
      exp_errcnt = 8'd1;
`else
      exp_errcnt = 8'd0;
`endif
      chk("t2_err_count", 32'(err_count), 32'(exp_errcnt));

      // unstable digit 0 never captures
      for (int i = 0; i < 10; i++) digit(0, (i % 2 == 0) ? pat(1) : pat(2), 2);
      chk("t3_no_capture0", 32'(dut.captured_q[0]), 32'd0);
      base = n_hs;
      digit(1, pat(6), 6);
      digit(2, pat(7), 6);
      digit(3, pat(8), 6);
      idle(6);
      chk("t3_no_frame", 32'(n_hs - base), 32'd0);
      push(16'h8765, 4'h0, 4'h0);
      digit(0, pat(5), 6);
      idle(6);
      chk("t3_frame_done", 32'(n_hs - base), 32'd1);

      // backpressure: first frame held while second fills
      frame_ready = 1'b0;
      base = n_hs;
      push(16'hCBA9, 4'h0, 4'h0);
      digit(0, pat(9), 6);
      digit(1, pat(10), 6);
      digit(2, pat(11), 6);
      digit(3, pat(12), 6);
      push(16'hFEDC, 4'h0, 4'h0);
      for (int k = 0; k < 4; k++) begin
         digit(k, pat(12 + k), 6);
         chk("t4_hold_valid", 32'(frame_valid), 32'd1);
         chk("t4_hold_data", 32'(frame_data), 32'hCBA9);
      end
      idle(2);
      chk("t4_hold_data_idle", 32'(frame_data), 32'hCBA9);
      frame_ready = 1'b1;
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      chk("t4_reload_valid", 32'(frame_valid), 32'd1);
      chk("t4_reload_data", 32'(frame_data), 32'hFEDC);
      chk("t4_first_taken", 32'(n_hs - base), 32'd1);
      idle(2);
      frame_ready = 1'b1;
      idle(4);
      chk("t4_second_taken", 32'(n_hs - base), 32'd2);
      chk("t4_valid_low", 32'(frame_valid), 32'd0);

      // two lows on dig_sel, then blank digit 3
      drive(4'b1100, pat(3), 10);
      chk("t5_no_capture", 32'(dut.captured_q), 32'd0);
      push(16'h0321, 4'h0, 4'b1000);
      digit(0, pat(1), 6);
      digit(1, pat(2), 6);
      digit(2, pat(3), 6);
      digit(3, 7'h7F, 6);
      idle(6);

      // reset mid-frame
      digit(0, pat(1), 6);
      digit(1, pat(2), 6);
      digit(2, pat(3), 6);
      chk("t6_pre_data", 32'(frame_data), 32'h0321);
      seg_in  = 7'h7F;
      dig_sel = 4'hF;
      rst_n   = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(frame_valid), 32'd0);
      chk("t6_rst_data", 32'(frame_data), 32'd0);
      chk("t6_rst_blank", 32'(frame_blank), 32'd0);
      chk("t6_rst_err", 32'(frame_err), 32'd0);
      chk("t6_rst_errcnt", 32'(err_count), 32'd0);
      chk("t6_rst_captured", 32'(dut.captured_q), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = n_hs;
      digit(3, pat(4), 6);
      idle(6);
      chk("t6_no_frame", 32'(n_hs - base), 32'd0);
      push(16'h4321, 4'h0, 4'h0);
      digit(0, pat(1), 6);
      digit(1, pat(2), 6);
      digit(2, pat(3), 6);
      idle(6);
      chk("t6_frame_after", 32'(n_hs - base), 32'd1);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
